imu_spi_responder: RTL and testbench

- SPI slave (mode 3) that emulates the MPU-9250 register interface as seen from the IMU SPI master.
- Hosts the config registers our init sequence writes and serves gyro burst reads from parallel sample inputs.
- Used as the gyro model in flight-loop benches and as a drop-in responder for HIL builds.
- All SPI pins are oversampled in the CLK domain; no second clock.

---
 rtl/imu_spi_responder_if.sv | 11 +
 rtl/imu_spi_responder.sv | 199 +++++++++++++++++++
 tb/tb_imu_spi_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imu_spi_responder_if.sv
// SPI pin bundle between an IMU SPI master and the imu_spi_responder slave.
interface imu_spi_responder_if;
    logic SCLK;
    logic MOSI;
    logic CS;
    logic MISO;
    logic MISO_OE;

    modport master (output SCLK, output MOSI, output CS, input MISO, input MISO_OE);
    modport slave  (input SCLK, input MOSI, input CS, output MISO, output MISO_OE);
endinterface

// File: rtl/imu_spi_responder.sv
// MPU-9250-style SPI mode-3 register responder, all pins oversampled in the CLK domain.
// Gyro burst reads are served from a snapshot taken at CS fall.
module imu_spi_responder #(
    parameter logic [7:0]  WHO_AM_I_VAL = 8'h71,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    imu_spi_responder_if.slave  spi,
    input  logic signed [15:0]  gyro_x,
    input  logic signed [15:0]  gyro_y,
    input  logic signed [15:0]  gyro_z,
    output logic [7:0]          cfg_smplrt_div,
    output logic [7:0]          cfg_config,
    output logic [7:0]          cfg_gyro_config,
    output logic [7:0]          cfg_accel_config,
    output logic [7:0]          cfg_int_pin_cfg,
    output logic [7:0]          cfg_pwr_mgmt_1,
    output logic                soft_reset,
    output logic                xfer_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic                   sclk_d, cs_d;
    logic [SYNC_STAGES:0]   live;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [1:0]  state;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic [6:0]  addr;
    logic        rw;
    logic        byte_seen;
    logic        miso_q;
    logic [15:0] snap_x, snap_y, snap_z;

    logic [7:0]  wr_byte;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_data;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sclk_sync <= '1;
            mosi_sync <= '1;
            cs_sync   <= '1;
            sclk_d    <= 1'b1;
            cs_d      <= 1'b1;
            live      <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.CS};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            live      <= {live[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;
    assign cs_rise   = ~cs_d & cs_s;
    // The reset-loaded 1s would fake a CS fall if CS is already low; only real samples may start a frame.
    assign cs_fall   = live[SYNC_STAGES] & cs_d & ~cs_s;

    assign wr_byte = {rx_shift, mosi_s};
    assign rd_addr = (state == ST_ADDR) ? wr_byte[6:0] : addr + 7'd1;

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            7'h19:   rd_data = cfg_smplrt_div;
            7'h1A:   rd_data = cfg_config;
            7'h1B:   rd_data = cfg_gyro_config;
            7'h1C:   rd_data = cfg_accel_config;
            7'h37:   rd_data = cfg_int_pin_cfg;
            7'h6B:   rd_data = cfg_pwr_mgmt_1;
            7'h43:   rd_data = snap_x[15:8];
            7'h44:   rd_data = snap_x[7:0];
            7'h45:   rd_data = snap_y[15:8];
            7'h46:   rd_data = snap_y[7:0];
            7'h47:   rd_data = snap_z[15:8];
            7'h48:   rd_data = snap_z[7:0];
            7'h75:   rd_data = WHO_AM_I_VAL;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state            <= ST_IDLE;
            bit_cnt          <= '0;
            rx_shift         <= '0;
            tx_shift         <= '0;
            addr             <= '0;
            rw               <= 1'b0;
            byte_seen        <= 1'b0;
            miso_q           <= 1'b0;
            snap_x           <= '0;
            snap_y           <= '0;
            snap_z           <= '0;
            cfg_smplrt_div   <= '0;
            cfg_config       <= '0;
            cfg_gyro_config  <= '0;
            cfg_accel_config <= '0;
            cfg_int_pin_cfg  <= '0;
            cfg_pwr_mgmt_1   <= 8'h01;
            soft_reset       <= 1'b0;
            xfer_done        <= 1'b0;
        end else begin
            soft_reset <= 1'b0;
            xfer_done  <= 1'b0;
            if (cs_rise) begin
                state     <= ST_IDLE;
                miso_q    <= 1'b0;
                xfer_done <= byte_seen;
                byte_seen <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        miso_q <= 1'b0;
                        if (cs_fall) begin
                            state     <= ST_ADDR;
                            bit_cnt   <= '0;
                            byte_seen <= 1'b0;
                            snap_x    <= gyro_x;
                            snap_y    <= gyro_y;
                            snap_z    <= gyro_z;
                        end
                    end
                    ST_ADDR: begin
                        miso_q <= 1'b0;
                        if (sclk_rise) begin
                            rx_shift <= wr_byte[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rw       <= wr_byte[7];
                                addr     <= wr_byte[6:0];
                                tx_shift <= rd_data;
                                state    <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (rw && sclk_fall) begin
                            miso_q   <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            rx_shift <= wr_byte[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_seen <= 1'b1;
                                addr      <= addr + 7'd1;
                                tx_shift  <= rd_data;
                                if (!rw) begin
                                    case (addr)
                                        7'h19: cfg_smplrt_div   <= wr_byte;
                                        7'h1A: cfg_config       <= wr_byte;
                                        7'h1B: cfg_gyro_config  <= wr_byte;
                                        7'h1C: cfg_accel_config <= wr_byte;
                                        7'h37: cfg_int_pin_cfg  <= wr_byte;
                                        7'h6B: begin
                                            if (wr_byte[7]) begin
                                                cfg_smplrt_div   <= '0;
                                                cfg_config       <= '0;
                                                cfg_gyro_config  <= '0;
                                                cfg_accel_config <= '0;
                                                cfg_int_pin_cfg  <= '0;
                                                cfg_pwr_mgmt_1   <= {1'b0, wr_byte[6:0]};
                                                soft_reset       <= 1'b1;
                                            end else begin
                                                cfg_pwr_mgmt_1 <= wr_byte;
                                            end
                                        end
                                        default: ;
                                    endcase
                                end
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign spi.MISO    = miso_q;
    assign spi.MISO_OE = ~cs_s;

endmodule

// File: tb/tb_imu_spi_responder.sv
// Bench for imu_spi_responder: SPI master driven from tasks, MISO bytes scored against a queue.
`timescale 1ns/1ps
module tb_imu_spi_responder;

    logic CLK = 1'b0;
    logic RESET;
    always #31.25 CLK = ~CLK;

    imu_spi_responder_if spi ();

    logic signed [15:0] gyro_x, gyro_y, gyro_z;
    logic [7:0] cfg_smplrt_div, cfg_config, cfg_gyro_config;
    logic [7:0] cfg_accel_config, cfg_int_pin_cfg, cfg_pwr_mgmt_1;
    logic       soft_reset, xfer_done;

    imu_spi_responder #(.WHO_AM_I_VAL(8'h71), .SYNC_STAGES(2)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .spi              (spi),
        .gyro_x           (gyro_x),
        .gyro_y           (gyro_y),
        .gyro_z           (gyro_z),
        .cfg_smplrt_div   (cfg_smplrt_div),
        .cfg_config       (cfg_config),
        .cfg_gyro_config  (cfg_gyro_config),
        .cfg_accel_config (cfg_accel_config),
        .cfg_int_pin_cfg  (cfg_int_pin_cfg),
        .cfg_pwr_mgmt_1   (cfg_pwr_mgmt_1),
        .soft_reset       (soft_reset),
        .xfer_done        (xfer_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int xd_cnt = 0;
    int sr_cnt = 0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    always @(posedge CLK) begin
        if (xfer_done)  xd_cnt <= xd_cnt + 1;
        if (soft_reset) sr_cnt <= sr_cnt + 1;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic spi_byte(input logic [7:0] b, input int half, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            spi.SCLK = 1'b0;
            spi.MOSI = b[i];
            clk_wait(half);
            spi.SCLK = 1'b1;
            r[i] = spi.MISO;
            clk_wait(half);
        end
    endtask

    task automatic spi_xfer(input int half);
        logic [7:0] t, r;
        rx_q.delete();
        spi.CS = 1'b0;
        clk_wait(8);
        while (tx_q.size() > 0) begin
            t = tx_q.pop_front();
            spi_byte(t, half, r);
            rx_q.push_back(r);
        end
        clk_wait(half);
        spi.CS = 1'b1;
        clk_wait(10);
    endtask

    task automatic test_reset;
        logic [7:0] a, e;
        int xd0;
        spi.CS = 1'b1; spi.SCLK = 1'b1; spi.MOSI = 1'b1;
        RESET = 1'b1;
        clk_wait(5);
        RESET = 1'b0;
        clk_wait(1);
        n_cmp++;
        if (cfg_pwr_mgmt_1 !== 8'h01) begin
            n_err++; $display("FAIL reset_pwr: got %02h expected 01", cfg_pwr_mgmt_1);
        end
        n_cmp++;
        if ({cfg_smplrt_div, cfg_config, cfg_gyro_config, cfg_accel_config, cfg_int_pin_cfg} !== 40'h0) begin
            n_err++; $display("FAIL reset_cfg: got %010h expected 0", {cfg_smplrt_div, cfg_config, cfg_gyro_config, cfg_accel_config, cfg_int_pin_cfg});
        end
        n_cmp++;
        if ({spi.MISO, spi.MISO_OE, soft_reset, xfer_done} !== 4'b0000) begin
            n_err++; $display("FAIL reset_pins: got %b expected 0000", {spi.MISO, spi.MISO_OE, soft_reset, xfer_done});
        end
        clk_wait(4);
        xd0 = xd_cnt;
        spi.CS = 1'b0;
        clk_wait(6);
        n_cmp++;
        if (spi.MISO_OE !== 1'b1) begin
            n_err++; $display("FAIL oe_low_cs: got %b expected 1", spi.MISO_OE);
        end
        spi.CS = 1'b1;
        clk_wait(6);
        n_cmp++;
        if (spi.MISO_OE !== 1'b0) begin
            n_err++; $display("FAIL oe_high_cs: got %b expected 0", spi.MISO_OE);
        end
        n_cmp++;
        if (xd_cnt !== xd0) begin
            n_err++; $display("FAIL zero_len_done: got %0d pulses expected 0", xd_cnt - xd0);
        end
        tx_q = '{8'hF5, 8'h00}; exp_q = '{8'h00, 8'h71};
        spi_xfer(8);
        tx_q = '{8'hEB, 8'h00}; exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        begin
            logic [7:0] first_rx[$];
            first_rx = rx_q;
            spi_xfer(8);
            rx_q = {first_rx, rx_q};
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++;
            if (a !== e) begin
                n_err++; $display("FAIL powerup_read: got %02h expected %02h", a, e);
            end
        end
    endtask

    task automatic test_config_writes;
        logic [7:0] a, e;
        int xd0;
        xd0 = xd_cnt;
        tx_q = '{8'h1B, 8'h10}; exp_q = '{8'h00, 8'h00};
        spi_xfer(8);
        n_cmp++;
        if (cfg_gyro_config !== 8'h10) begin
            n_err++; $display("FAIL single_write: got %02h expected 10", cfg_gyro_config);
        end
        n_cmp++;
        if (xd_cnt - xd0 !== 1) begin
            n_err++; $display("FAIL write_done: got %0d pulses expected 1", xd_cnt - xd0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++;
            if (a !== e) begin
                n_err++; $display("FAIL write_miso: got %02h expected %02h", a, e);
            end
        end
        tx_q = '{8'h19, 8'h00, 8'h07, 8'h10, 8'h18};
        spi_xfer(8);
        tx_q = '{8'h37, 8'h22};
        spi_xfer(8);
        n_cmp++;
        if ({cfg_smplrt_div, cfg_config, cfg_gyro_config, cfg_accel_config, cfg_int_pin_cfg} !== 40'h00_07_10_18_22) begin
            n_err++; $display("FAIL burst_write: got %010h expected 0007101822", {cfg_smplrt_div, cfg_config, cfg_gyro_config, cfg_accel_config, cfg_int_pin_cfg});
        end
        tx_q = '{8'h99, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_q = '{8'h00, 8'h00, 8'h07, 8'h10, 8'h18};
        spi_xfer(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++;
            if (a !== e) begin
                n_err++; $display("FAIL cfg_readback: got %02h expected %02h", a, e);
            end
        end
    endtask

    task automatic test_gyro_burst;
        logic [7:0] a, e;
        int xd0;
        gyro_x = 16'sh1234; gyro_y = 16'shFF00; gyro_z = 16'sh8001;
        tx_q = '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        spi_xfer(2);
        $display("note: 4x oversampled burst returned %p", rx_q);
        xd0 = xd_cnt;
        tx_q = '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_q = '{8'h00, 8'h12, 8'h34, 8'hFF, 8'h00, 8'h80, 8'h01};
        fork
            spi_xfer(8);
            begin
                clk_wait(300);
                gyro_x = 16'sh5A5A; gyro_y = 16'sh0F0F; gyro_z = 16'sh7777;
            end
        join
        n_cmp++;
        if (xd_cnt - xd0 !== 1) begin
            n_err++; $display("FAIL burst_done: got %0d pulses expected 1", xd_cnt - xd0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++;
            if (a !== e) begin
                n_err++; $display("FAIL gyro_burst: got %02h expected %02h", a, e);
            end
        end
    endtask

    task automatic test_soft_reset;
        int sr0;
        sr0 = sr_cnt;
        tx_q = '{8'h6B, 8'h80};
        spi_xfer(8);
        n_cmp++;
        if (sr_cnt - sr0 !== 1) begin
            n_err++; $display("FAIL soft_reset_pulse: got %0d pulses expected 1", sr_cnt - sr0);
        end
        n_cmp++;
        if ({cfg_smplrt_div, cfg_config, cfg_gyro_config, cfg_accel_config, cfg_int_pin_cfg, cfg_pwr_mgmt_1} !== 48'h0) begin
            n_err++; $display("FAIL soft_reset_cfg: got %012h expected 0", {cfg_smplrt_div, cfg_config, cfg_gyro_config, cfg_accel_config, cfg_int_pin_cfg, cfg_pwr_mgmt_1});
        end
    endtask

    task automatic test_abort_wrap;
        logic [7:0] a, e, r;
        logic [7:0] pat;
        int xd0;
        tx_q = '{8'h1A, 8'h55};
        spi_xfer(8);
        xd0 = xd_cnt;
        pat = 8'hAA;
        spi.CS = 1'b0;
        clk_wait(8);
        spi_byte(8'h1A, 8, r);
        for (int i = 7; i >= 3; i--) begin
            spi.SCLK = 1'b0; spi.MOSI = pat[i]; clk_wait(8);
            spi.SCLK = 1'b1; clk_wait(8);
        end
        spi.CS = 1'b1;
        clk_wait(10);
        n_cmp++;
        if (cfg_config !== 8'h55) begin
            n_err++; $display("FAIL abort_write: got %02h expected 55", cfg_config);
        end
        n_cmp++;
        if (xd_cnt !== xd0) begin
            n_err++; $display("FAIL abort_done: got %0d pulses expected 0", xd_cnt - xd0);
        end
        // SCLK activity with CS high must not disturb the next frame
        for (int i = 0; i < 8; i++) begin
            spi.SCLK = 1'b0; spi.MOSI = i[0]; clk_wait(4);
            spi.SCLK = 1'b1; clk_wait(4);
        end
        gyro_x = 16'sh1234;
        tx_q = '{8'h6B, 8'h41};
        spi_xfer(8);
        tx_q = '{8'h43, 8'h55, 8'h66};
        spi_xfer(8);
        tx_q = '{8'hEA, 8'h00, 8'h00};
        exp_q = '{8'h00, 8'h00, 8'h41};
        spi_xfer(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++;
            if (a !== e) begin
                n_err++; $display("FAIL incr_read: got %02h expected %02h", a, e);
            end
        end
        tx_q = '{8'hC3, 8'h00, 8'h00};
        exp_q = '{8'h00, 8'h12, 8'h34};
        spi_xfer(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++;
            if (a !== e) begin
                n_err++; $display("FAIL ro_gyro: got %02h expected %02h", a, e);
            end
        end
        tx_q = '{8'hFF, 8'h00, 8'h00};
        exp_q = '{8'h00, 8'h00, 8'h00};
        spi_xfer(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++;
            if (a !== e) begin
                n_err++; $display("FAIL wrap_read: got %02h expected %02h", a, e);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        logic [7:0] a, e, r;
        logic       miso_or;
        int xd0;
        tx_q = '{8'h1B, 8'h18};
        spi_xfer(8);
        gyro_x = 16'shFFFF;
        spi.CS = 1'b0;
        clk_wait(8);
        spi_byte(8'hC3, 8, r);
        spi_byte(8'h00, 8, r);
        for (int i = 0; i < 3; i++) begin
            spi.SCLK = 1'b0; spi.MOSI = 1'b0; clk_wait(8);
            spi.SCLK = 1'b1; clk_wait(8);
        end
        RESET = 1'b1;
        clk_wait(3);
        RESET = 1'b0;
        xd0 = xd_cnt;
        miso_or = 1'b0;
        for (int i = 0; i < 13; i++) begin
            spi.SCLK = 1'b0; spi.MOSI = 1'b0; clk_wait(8);
            spi.SCLK = 1'b1; miso_or = miso_or | spi.MISO; clk_wait(8);
        end
        n_cmp++;
        if (miso_or !== 1'b0) begin
            n_err++; $display("FAIL miso_after_reset: got %b expected 0", miso_or);
        end
        n_cmp++;
        if (cfg_gyro_config !== 8'h00) begin
            n_err++; $display("FAIL reset_mid_cfg: got %02h expected 00", cfg_gyro_config);
        end
        spi.CS = 1'b1;
        clk_wait(10);
        n_cmp++;
        if (xd_cnt !== xd0) begin
            n_err++; $display("FAIL reset_mid_done: got %0d pulses expected 0", xd_cnt - xd0);
        end
        tx_q = '{8'hF5, 8'h00};
        exp_q = '{8'h00, 8'h71};
        spi_xfer(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++;
            if (a !== e) begin
                n_err++; $display("FAIL after_reset_read: got %02h expected %02h", a, e);
            end
        end
    endtask

    initial begin
        gyro_x = '0; gyro_y = '0; gyro_z = '0;
        test_reset();
        test_config_writes();
        test_gyro_burst();
        test_soft_reset();
        test_abort_wrap();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
